// File: rtl/anim_timer_bank_pkg.sv
// Shared definitions for the animation timer bank: default sizing,
// mode encodings and the width helper used for address ports.
package anim_timer_bank_pkg;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_PRESCALE = 1000;
  localparam int BYTES        = DEF_CNT_W / DEF_DATA_W;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Address width for n selectable items; never narrower than one bit so
  // single-item configurations still get a usable port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/anim_timer_bank_timer_channel.sv
// One countdown channel: byte-programmable reload, one-shot/periodic mode,
// stop > start > tick priority and a registered terminal-count pulse.
module timer_channel
  import anim_timer_bank_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BY_W   = clog2_min1(DEF_CNT_W / DEF_DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [BY_W-1:0]   wr_byte,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mode_wr_en,
  input  logic              mode_in,
  input  logic              start,
  input  logic              stop,
  output logic [CNT_W-1:0]  count,
  output logic              expire
);

  logic [CNT_W-1:0] reload;
  logic             periodic;
  logic [CNT_W-1:0] count_nxt;
  logic             expire_nxt;

  // Reload and mode registers; the top only asserts the enables for in-range addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload   <= '0;
      periodic <= MODE_ONESHOT;
    end else begin
      if (wr_en) begin
        reload[int'(wr_byte)*DATA_W +: DATA_W] <= wr_data;
      end
      if (mode_wr_en) begin
        periodic <= mode_in;
      end
    end
  end

  // Next count: stop beats start beats tick; reload here is the pre-write value.
  always_comb begin
    count_nxt  = count;
    expire_nxt = 1'b0;
    if (stop) begin
      count_nxt = '0;
    end else if (start) begin
      count_nxt = reload;
    end else if (tick && (count != '0)) begin
      if (count == CNT_W'(1)) begin
        expire_nxt = 1'b1;
        count_nxt  = (periodic == MODE_PERIODIC) ? reload : '0;
      end else begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  // Count and expire registers; reset drops any pending expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      expire <= 1'b0;
    end else begin
      count  <= count_nxt;
      expire <= expire_nxt;
    end
  end

endmodule

// File: rtl/anim_timer_bank.sv
// Bank of NUM_CH countdown timers with shared tick, write address decode
// and byte readback of the live counts.
// Optional shared prescaler is built only when TIMER_PRESCALE_EN is defined;
// otherwise every cycle is a tick and PRESCALE is unused.
module anim_timer_bank
  import anim_timer_bank_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic                                   mode_wr_en,
  input  logic [clog2_min1(NUM_CH)-1:0]          wr_ch,
  input  logic [clog2_min1(CNT_W/DATA_W)-1:0]    wr_byte,
  input  logic [DATA_W-1:0]                      wr_data,
  input  logic                                   mode_in,
  input  logic [NUM_CH-1:0]                      start,
  input  logic [NUM_CH-1:0]                      stop,
  input  logic [clog2_min1(NUM_CH)-1:0]          rd_ch,
  input  logic [clog2_min1(CNT_W/DATA_W)-1:0]    rd_byte,
  output logic [DATA_W-1:0]                      rd_data,
  output logic [NUM_CH-1:0]                      busy,
  output logic [NUM_CH-1:0]                      expire
);

  localparam int NBYTES = CNT_W / DATA_W;
  localparam int CH_W   = clog2_min1(NUM_CH);
  localparam int BY_W   = clog2_min1(NBYTES);
  localparam logic [BY_W:0] NBYTES_V = (BY_W+1)'(NBYTES);

  logic                wr_byte_ok;
  logic                rd_byte_ok;
  logic [NUM_CH-1:0]   wr_hit;
  logic [NUM_CH-1:0]   mode_hit;
  logic [CNT_W-1:0]    counts [NUM_CH];
  logic                tick;

`ifdef TIMER_PRESCALE_EN
  localparam int PS_W = clog2_min1(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] pre_cnt;

  assign tick = (pre_cnt == PS_LAST);

  // Free-running prescaler shared by all channels; start does not resync it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PS_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign wr_byte_ok = ({1'b0, wr_byte} < NBYTES_V);
  assign rd_byte_ok = ({1'b0, rd_byte} < NBYTES_V);

  // Write decode; channel indices beyond NUM_CH never match so those writes vanish.
  always_comb begin
    wr_hit   = '0;
    mode_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CH_W'(c)) begin
        wr_hit[c]   = wr_en && wr_byte_ok;
        mode_hit[c] = mode_wr_en;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W),
      .BY_W   (BY_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .wr_en      (wr_hit[c]),
      .wr_byte    (wr_byte),
      .wr_data    (wr_data),
      .mode_wr_en (mode_hit[c]),
      .mode_in    (mode_in),
      .start      (start[c]),
      .stop       (stop[c]),
      .count      (counts[c]),
      .expire     (expire[c])
    );

    assign busy[c] = (counts[c] != '0);
  end

  // Readback mux of the live count; out-of-range selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((rd_ch == CH_W'(c)) && rd_byte_ok) begin
        rd_data = counts[c][int'(rd_byte)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_anim_timer_bank.sv
// Testbench for anim_timer_bank: directed scenarios plus a random phase,
// every cycle compared against a behavioural model of the timer rules.
// Three channels are used so channel index 3 is a representable,
// out-of-range address.
module tb_anim_timer_bank;

  localparam int NCH = 3;
  localparam int PS  = 4;
`ifdef TIMER_PRESCALE_EN
  localparam int SC  = PS;
`else
  localparam int SC  = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, mode_wr_en, mode_in;
  logic [1:0] wr_ch, wr_byte, rd_ch, rd_byte;
  logic [7:0] wr_data;
  logic [2:0] start, stop;
  logic [7:0] rd_data;
  logic [2:0] busy, expire;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] m_reload [NCH];
  bit [31:0] m_count  [NCH];
  bit        m_per    [NCH];
  bit        m_exp    [NCH];
  int        m_pre;

  anim_timer_bank #(
    .NUM_CH   (NCH),
    .CNT_W    (32),
    .DATA_W   (8),
    .PRESCALE (PS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .mode_wr_en (mode_wr_en),
    .wr_ch      (wr_ch),
    .wr_byte    (wr_byte),
    .wr_data    (wr_data),
    .mode_in    (mode_in),
    .start      (start),
    .stop       (stop),
    .rd_ch      (rd_ch),
    .rd_byte    (rd_byte),
    .rd_data    (rd_data),
    .busy       (busy),
    .expire     (expire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: applies the timer rules to the inputs present at this edge.
  task automatic model_step();
    bit tick;
    bit [31:0] old_rel;
    bit old_per;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_reload[c] = 0; m_count[c] = 0; m_per[c] = 0; m_exp[c] = 0;
      end
      m_pre = 0;
    end else begin
      tick = 1'b1;
`ifdef TIMER_PRESCALE_EN
      tick  = (m_pre == PS - 1);
      m_pre = tick ? 0 : m_pre + 1;
`endif
      for (int c = 0; c < NCH; c++) begin
        old_rel  = m_reload[c];
        old_per  = m_per[c];
        m_exp[c] = 1'b0;
        if (stop[c]) m_count[c] = 0;
        else if (start[c]) m_count[c] = old_rel;
        else if (tick && m_count[c] > 0) begin
          if (m_count[c] == 1) begin
            m_exp[c]   = 1'b1;
            m_count[c] = old_per ? old_rel : 0;
          end else begin
            m_count[c] = m_count[c] - 1;
          end
        end
        if (wr_en && int'(wr_ch) == c)
          m_reload[c][int'(wr_byte)*8 +: 8] = wr_data;
        if (mode_wr_en && int'(wr_ch) == c)
          m_per[c] = mode_in;
      end
    end
  endtask

  function automatic logic [7:0] m_rd();
    if (int'(rd_ch) < NCH) return m_count[rd_ch][int'(rd_byte)*8 +: 8];
    return 8'h00;
  endfunction

  task automatic cycle();
    logic [2:0] mb, me;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      mb[c] = (m_count[c] != 0);
      me[c] = m_exp[c];
    end
    chk("model_busy", 32'(busy), 32'(mb));
    chk("model_expire", 32'(expire), 32'(me));
    chk("model_rd_data", 32'(rd_data), 32'(m_rd()));
  endtask

  task automatic idle();
    wr_en = 0; mode_wr_en = 0; start = '0; stop = '0;
  endtask

  task automatic wr(input int ch, input int by, input int dat);
    wr_en = 1; wr_ch = 2'(ch); wr_byte = 2'(by); wr_data = 8'(dat);
    cycle();
    idle();
  endtask

  initial begin
    int nb, ne, first;
    rst = 1; idle(); mode_in = 0; wr_ch = 0; wr_byte = 0; wr_data = 0;
    rd_ch = 0; rd_byte = 0;
    m_pre = 0;
    for (int c = 0; c < NCH; c++) begin
      m_reload[c] = 0; m_count[c] = 0; m_per[c] = 0; m_exp[c] = 0;
    end
    cycle(); cycle();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_expire", 32'(expire), 0);
    chk("reset_rd", 32'(rd_data), 0);
    rst = 0;

    // One-shot reload 5 on ch0
    wr(0, 0, 8'h05); wr(0, 1, 0); wr(0, 2, 0); wr(0, 3, 0);
    rd_ch = 0; rd_byte = 0;
    start = 3'b001; cycle(); idle();
    nb = int'(busy[0]); ne = 0;
    for (int i = 1; i <= 7 * SC; i++) begin
      cycle();
      nb += int'(busy[0]); ne += int'(expire[0]);
    end
`ifndef TIMER_PRESCALE_EN
    chk("oneshot_busy_cycles", 32'(nb), 5);
`endif
    chk("oneshot_expire_count", 32'(ne), 1);
    chk("oneshot_final_count", 32'(rd_data), 0);

    // Periodic reload 3 on ch1, mode and reload written in the same cycle
    wr_en = 1; mode_wr_en = 1; wr_ch = 1; wr_byte = 0; wr_data = 8'h03; mode_in = 1;
    cycle(); idle();
    rd_ch = 1;
    start = 3'b010; cycle(); idle();
    ne = 0;
    for (int i = 1; i <= 12 * SC; i++) begin
      cycle();
      ne += int'(expire[1]);
`ifndef TIMER_PRESCALE_EN
      chk("periodic_phase", 32'(expire[1]), 32'(i % 3 == 0));
`endif
    end
    chk("periodic_pulses", 32'(ne), 4);
    cycle();
    stop = 3'b010; cycle(); idle();
    chk("periodic_stop_rd", 32'(rd_data), 0);
    chk("periodic_stop_busy", 32'(busy[1]), 0);
    ne = 0;
    for (int i = 0; i < 6 * SC; i++) begin
      cycle(); ne += int'(expire[1]);
    end
    chk("periodic_after_stop", 32'(ne), 0);

    // Start uses pre-write reload when written in the same cycle
    rd_ch = 0; rd_byte = 0;
    wr_en = 1; wr_ch = 0; wr_byte = 0; wr_data = 8'h09; start = 3'b001;
    cycle(); idle();
    chk("start_old_reload", 32'(rd_data), 5);
    stop = 3'b001; cycle(); idle();
    start = 3'b001; cycle(); idle();
    chk("start_new_reload", 32'(rd_data), 9);
    stop = 3'b001; cycle(); idle();

    // stop beats start; zero reload start is a no-op
    start = 3'b001; stop = 3'b001; cycle(); idle();
    chk("stop_wins_busy", 32'(busy[0]), 0);
    chk("stop_wins_rd", 32'(rd_data), 0);
    cycle();
    chk("stop_wins_no_expire", 32'(expire[0]), 0);
    start = 3'b100; cycle(); idle();
    chk("zero_reload_busy", 32'(busy[2]), 0);
    cycle();
    chk("zero_reload_expire", 32'(expire[2]), 0);

    // Out-of-range write and readback
    wr_en = 1; mode_wr_en = 1; mode_in = 1; wr_ch = 2'd3; wr_byte = 0; wr_data = 8'h77;
    cycle(); idle();
    rd_ch = 2'd3; rd_byte = 0;
    cycle();
    chk("oor_read", 32'(rd_data), 0);
    start = 3'b111; cycle(); idle();
    rd_ch = 0; #1;
    chk("oor_ch0_reload", 32'(rd_data), 9);
    rd_ch = 1; #1;
    chk("oor_ch1_reload", 32'(rd_data), 3);
    chk("oor_ch2_idle", 32'(busy[2]), 0);
    stop = 3'b111; cycle(); idle();

`ifdef TIMER_PRESCALE_EN
    wr(0, 0, 8'h02);
    rd_ch = 0;
    start = 3'b001; cycle(); idle();
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (expire[0] && first == 0) first = i;
    end
    chk("prescale_window", 32'(first >= 5 && first <= 8), 1);
`else
    first = 0;
`endif

    // Reset on the edge that would have produced an expiry
    rd_ch = 0; rd_byte = 0;
    start = 3'b001; cycle(); idle();
    for (int i = 0; i < 8; i++) cycle();
    rst = 1; cycle();
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_expire", 32'(expire), 0);
    chk("rst_mid_rd", 32'(rd_data), 0);
    rst = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_ch      = 2'($urandom_range(0, 3));
      wr_byte    = 2'($urandom_range(0, 3));
      wr_data    = (wr_byte == 0) ? 8'($urandom_range(0, 7))
                                  : 8'($urandom_range(0, 7) == 0);
      mode_wr_en = ($urandom_range(0, 7) == 0);
      mode_in    = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 5) == 0);
        stop[c]  = ($urandom_range(0, 11) == 0);
      end
      rd_ch   = 2'($urandom_range(0, 3));
      rd_byte = 2'($urandom_range(0, 3));
      cycle();
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
